// File: rtl/lsu_pkg.sv
// lsu_pkg: access-size encodings, FSM states and misalignment check for the load/store unit
package lsu_pkg;
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    RMW_RD = 3'd2,
    WR     = 3'd3,
    RESP   = 3'd4
  } state_t;
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] offset);
    return (size == SIZE_HALF && offset[0]) || (size == SIZE_WORD && offset != 2'b00) || size == 2'b11;
  endfunction
endpackage

// File: rtl/lsu_byte_lane.sv
// lsu_byte_lane: little-endian lane extract/extend for loads and lane merge for sub-word stores
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] merged
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = word[{offset, 3'b000} +: 8];
    h = offset[1] ? word[31:16] : word[15:0];
    rdata = size == SIZE_BYTE ? {{24{~is_unsigned & b[7]}}, b} :
            size == SIZE_HALF ? {{16{~is_unsigned & h[15]}}, h} : word;
    merged = word;
    if (size == SIZE_BYTE) merged[{offset, 3'b000} +: 8] = wdata[7:0];
    else if (size == SIZE_HALF) merged[{offset[1], 4'b0000} +: 16] = wdata[15:0];
    else merged = wdata;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage request/response to word-wide DataMemory with sub-word RMW and misalignment errors
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_misaligned,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writeData,
  output logic              mem_writeEnable,
  output logic              mem_readEnable,
  input  logic [DATA_W-1:0] mem_readData
);
  state_t            state;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wr_word;
  logic [DATA_W-1:0] lane_rdata;
  logic [DATA_W-1:0] lane_merged;
  logic              mis;
  assign mis             = misaligned(req_size, req_addr[1:0]);
  assign req_ready       = state == IDLE;
  assign rsp_valid       = state == RESP;
  assign mem_readEnable  = state == RD || state == RMW_RD;
  assign mem_writeEnable = state == WR;
  assign mem_address     = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_writeData   = wr_word;
  // wr_word holds the raw store data until RMW_RD replaces it with the merged word
  lsu_byte_lane u_lane (
    .word       (mem_readData),
    .offset     (addr_q[1:0]),
    .size       (size_q),
    .is_unsigned(uns_q),
    .wdata      (wr_word),
    .rdata      (lane_rdata),
    .merged     (lane_merged)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      size_q         <= 2'b00;
      uns_q          <= 1'b0;
      addr_q         <= '0;
      wr_word        <= '0;
      rsp_rdata      <= '0;
      rsp_misaligned <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          size_q         <= req_size;
          uns_q          <= req_unsigned;
          addr_q         <= req_addr;
          wr_word        <= req_wdata;
          rsp_rdata      <= '0;
          rsp_misaligned <= mis;
          state          <= mis ? RESP : !req_write ? RD : req_size == SIZE_WORD ? WR : RMW_RD;
        end
        RD: begin
          rsp_rdata <= lane_rdata;
          state     <= RESP;
        end
        RMW_RD: begin
          wr_word <= lane_merged;
          state   <= WR;
        end
        WR:      state <= RESP;
        RESP:    if (rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vector table plus back-pressure and mid-operation reset sequences
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_misaligned;
  logic [31:0] mem_address;
  logic [31:0] mem_writeData;
  logic        mem_writeEnable;
  logic        mem_readEnable;
  logic [31:0] mem_readData;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_misaligned(rsp_misaligned),
    .mem_address(mem_address), .mem_writeData(mem_writeData), .mem_writeEnable(mem_writeEnable),
    .mem_readEnable(mem_readEnable), .mem_readData(mem_readData)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:63];
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          both_cnt = 0;
  logic [31:0] strobe_addr = '0;
  assign mem_readData = mem[mem_address[7:2]];

  always @(posedge clk) begin
    if (mem_readEnable) begin
      rd_cnt      <= rd_cnt + 1;
      strobe_addr <= mem_address;
    end
    if (mem_writeEnable) begin
      wr_cnt                  <= wr_cnt + 1;
      strobe_addr             <= mem_address;
      mem[mem_address[7:2]]   <= mem_writeData;
    end
    if (mem_readEnable && mem_writeEnable) both_cnt <= both_cnt + 1;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        mis;
    int          lat;
    int          rd;
    int          wrn;
    logic [31:0] word;
  } vec_t;

  vec_t v[19];

  task automatic run_req(input int idx, input vec_t t);
    int lat, r0, w0;
    @(negedge clk);
    check($sformatf("v%0d req_ready", idx), {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = t.wr; req_size = t.size; req_unsigned = t.uns;
    req_addr = t.addr; req_wdata = t.wdata;
    r0 = rd_cnt; w0 = wr_cnt;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("v%0d latency", idx), lat, t.lat);
    check($sformatf("v%0d rdata", idx), rsp_rdata, t.rdata);
    check($sformatf("v%0d misaligned", idx), {31'd0, rsp_misaligned}, {31'd0, t.mis});
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check($sformatf("v%0d rsp_valid drop", idx), {31'd0, rsp_valid}, 32'd0);
    check($sformatf("v%0d read strobes", idx), rd_cnt - r0, t.rd);
    check($sformatf("v%0d write strobes", idx), wr_cnt - w0, t.wrn);
    check($sformatf("v%0d mem word", idx), mem[4], t.word);
    if (t.rd + t.wrn > 0) check($sformatf("v%0d strobe addr", idx), strobe_addr, {t.addr[31:2], 2'b00});
  endtask

  initial begin
    int w0, r0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[4] = 32'h8899AABB;
    //      wr   size   uns   addr        wdata          rdata          mis   lat rd wr word
    v[0]  = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0,         32'h8899AABB, 1'b0, 2, 1, 0, 32'h8899AABB};
    v[1]  = '{1'b0, 2'b00, 1'b0, 32'h13, 32'h0,         32'hFFFFFF88, 1'b0, 2, 1, 0, 32'h8899AABB};
    v[2]  = '{1'b0, 2'b00, 1'b1, 32'h13, 32'h0,         32'h00000088, 1'b0, 2, 1, 0, 32'h8899AABB};
    v[3]  = '{1'b0, 2'b01, 1'b0, 32'h12, 32'h0,         32'hFFFF8899, 1'b0, 2, 1, 0, 32'h8899AABB};
    v[4]  = '{1'b0, 2'b01, 1'b1, 32'h10, 32'h0,         32'h0000AABB, 1'b0, 2, 1, 0, 32'h8899AABB};
    v[5]  = '{1'b1, 2'b00, 1'b0, 32'h11, 32'hDEADBECC,  32'h0,        1'b0, 3, 1, 1, 32'h8899CCBB};
    v[6]  = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0,         32'h8899CCBB, 1'b0, 2, 1, 0, 32'h8899CCBB};
    v[7]  = '{1'b1, 2'b10, 1'b0, 32'h10, 32'h12345678,  32'h0,        1'b0, 2, 0, 1, 32'h12345678};
    v[8]  = '{1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF5566,  32'h0,        1'b0, 3, 1, 1, 32'h55665678};
    v[9]  = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0,         32'h55665678, 1'b0, 2, 1, 0, 32'h55665678};
    v[10] = '{1'b0, 2'b01, 1'b0, 32'h11, 32'h0,         32'h0,        1'b1, 1, 0, 0, 32'h55665678};
    v[11] = '{1'b1, 2'b10, 1'b0, 32'h12, 32'hCAFEBABE,  32'h0,        1'b1, 1, 0, 0, 32'h55665678};
    v[12] = '{1'b0, 2'b11, 1'b1, 32'h10, 32'h0,         32'h0,        1'b1, 1, 0, 0, 32'h55665678};
    v[13] = '{1'b0, 2'b00, 1'b1, 32'h12, 32'h0,         32'h00000066, 1'b0, 2, 1, 0, 32'h55665678};
    v[14] = '{1'b0, 2'b00, 1'b0, 32'h13, 32'h0,         32'h00000055, 1'b0, 2, 1, 0, 32'h55665678};
    v[15] = '{1'b1, 2'b00, 1'b0, 32'h10, 32'h000000F0,  32'h0,        1'b0, 3, 1, 1, 32'h556656F0};
    v[16] = '{1'b0, 2'b00, 1'b0, 32'h10, 32'h0,         32'hFFFFFFF0, 1'b0, 2, 1, 0, 32'h556656F0};
    v[17] = '{1'b0, 2'b01, 1'b0, 32'h12, 32'h0,         32'h00005566, 1'b0, 2, 1, 0, 32'h556656F0};
    v[18] = '{1'b1, 2'b11, 1'b0, 32'h10, 32'h11111111,  32'h0,        1'b1, 1, 0, 0, 32'h556656F0};

    repeat (2) @(posedge clk);
    #1;
    check("reset req_ready", {31'd0, req_ready}, 32'd1);
    check("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset rsp_rdata", rsp_rdata, 32'd0);
    check("reset rsp_misaligned", {31'd0, rsp_misaligned}, 32'd0);
    check("reset mem_address", mem_address, 32'd0);
    check("reset mem_writeData", mem_writeData, 32'd0);
    check("reset enables", {30'd0, mem_readEnable, mem_writeEnable}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) run_req(i, v[i]);

    // back-pressure: response held for 5 cycles while a store waits on req_valid
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h10;
    @(posedge clk); #1;
    req_write = 1'b1; req_wdata = 32'hCAFEF00D;
    w0 = wr_cnt;
    for (int i = 0; i < 10 && !rsp_valid; i++) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp%0d rsp_valid", i), {31'd0, rsp_valid}, 32'd1);
      check($sformatf("bp%0d rsp_rdata", i), rsp_rdata, 32'h556656F0);
      check($sformatf("bp%0d req_ready", i), {31'd0, req_ready}, 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0; req_valid = 1'b0;
    check("bp rsp_valid drop", {31'd0, rsp_valid}, 32'd0);
    check("bp req_ready", {31'd0, req_ready}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("bp store ignored", wr_cnt - w0, 0);
    check("bp mem word", mem[4], 32'h556656F0);

    // reset while in WR
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_addr = 32'h10; req_wdata = 32'hA5A5A5A5;
    w0 = wr_cnt;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("wr phase writeEnable", {31'd0, mem_writeEnable}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rst wr writeEnable", {31'd0, mem_writeEnable}, 32'd0);
    check("rst wr rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst wr req_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst wr idle", {31'd0, req_ready}, 32'd1);
    check("rst wr no write", wr_cnt - w0, 0);
    check("rst wr mem word", mem[4], 32'h556656F0);

    // reset while in RMW_RD leaves memory untouched
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_addr = 32'h10; req_wdata = 32'h11;
    w0 = wr_cnt; r0 = rd_cnt;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rmw phase readEnable", {31'd0, mem_readEnable}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rst rmw readEnable", {31'd0, mem_readEnable}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst rmw no read", rd_cnt - r0, 0);
    check("rst rmw no write", wr_cnt - w0, 0);
    check("rst rmw mem word", mem[4], 32'h556656F0);

    run_req(19, '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h556656F0, 1'b0, 2, 1, 0, 32'h556656F0});
    check("enables never both high", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface: accepts load/store requests from the CPU memory stage and drives the word-wide DataMemory port.
- Handles byte, halfword and word accesses; performs sign/zero extension on loads and read-modify-write on sub-word stores.
- Detects misaligned accesses and answers them with an error response, without touching memory.
- Sits between the pipeline MEM stage (valid/ready request/response) and DataMemory.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, memory word width. Fixed at 32; byte-lane logic is defined only for 32.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_write  in  1  1=store, 0=load
- req_size  in  2  00=byte, 01=half, 10=word, 11=illegal
- req_unsigned  in  1  load zero-extends when 1
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data, right-justified
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  DATA_W  extended load data; 0 for stores and errors
- rsp_misaligned  out  1  access rejected
- mem_address  out  ADDR_W  word-aligned byte address {addr[31:2],2'b00}
- mem_writeData  out  DATA_W  word to write
- mem_writeEnable  out  1  write strobe, exactly one cycle per write
- mem_readEnable  out  1  read strobe
- mem_readData  in  DATA_W  combinational read data from DataMemory

Behaviour:
- Reset: state=IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_misaligned=0; mem_address=0; mem_writeData=0; both enables=0.
- Byte lanes are little-endian: byte k = bits[8k+7:8k], selected by addr[1:0]. Halfword uses bits[15:0] when addr[1]=0 and bits[31:16] when addr[1]=1.
- Misaligned when any of these holds: half with addr[0]=1; word with addr[1:0]!=0; size=11.
- States and transitions:
  - IDLE: req_ready=1. On req_valid, latch write/size/unsigned/addr/wdata. Then go to RESP (misaligned, error set), RD (load), WR (word store) or RMW_RD (byte/half store).
  - RD: mem_readEnable=1 for one cycle. Register mem_readData, extract the lane, sign- or zero-extend into rsp_rdata. Then go to RESP.
  - RMW_RD: mem_readEnable=1 for one cycle. Capture mem_readData and merge req_wdata's low byte/half into the addressed lane. Then go to WR.
  - WR: mem_writeEnable=1 for one cycle. mem_writeData is the merged word, or req_wdata for a word store. Then go to RESP.
  - RESP: rsp_valid=1 with rsp_rdata/rsp_misaligned held stable until rsp_ready=1 on a clock edge. Then go to IDLE; rsp_valid drops on the next cycle.
- Latency from accept edge to rsp_valid:
  - misaligned: 1 cycle
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
- Throughput is one request in flight; no new request is accepted while in RESP.
- mem_address is valid and stable throughout RD/RMW_RD/WR. Enables are decoded from state and are never both high.
- A misaligned request never asserts either enable.
- Reset asserted mid-operation: the state machine returns to IDLE immediately (asynchronously); enables and rsp_valid drop at once. An interrupted RMW leaves memory untouched if reset hits before WR.
- req_valid in non-IDLE states is ignored; the requester must hold it until req_ready.

Decomposition:
- Package lsu_pkg holds:
  - SIZE_BYTE/SIZE_HALF/SIZE_WORD encodings
  - state enum {IDLE, RD, RMW_RD, WR, RESP}
  - a misalignment check function
- Sub-module lsu_byte_lane (combinational) provides:
  - load extract+extend (word, addr[1:0], size, unsigned → rdata)
  - store merge (old word, wdata, addr[1:0], size → new word)
- The top level contains only the FSM and registers.

Test Plan:
- Bench uses a behavioural DataMemory preloaded with word 0x10 = 0x8899AABB.
- LW 0x10 → mem_readEnable high for exactly 1 cycle at address 0x10; rsp_valid 2 cycles after accept; rsp_rdata=0x8899AABB; rsp_misaligned=0.
- Extension checks:
  - LB 0x13 → 0xFFFFFF88
  - LBU 0x13 → 0x00000088
  - LH 0x12 → 0xFFFF8899
  - LHU 0x10 → 0x0000AABB
- SB 0x11 with wdata 0xDEADBECC → one read cycle, then one write with mem_writeData=0x8899CCBB; rsp after 3 cycles; a following LW 0x10 returns 0x8899CCBB.
- SW 0x10 with 0x12345678 → no read strobe; single write of 0x12345678; rsp after 2 cycles. SH 0x12 with 0xFFFF5566 then LW → 0x55665678.
- Error path: LH 0x11, SW 0x12 and size=11 each → rsp_misaligned=1 after 1 cycle, rsp_rdata=0, both enables stay 0, memory unchanged.
- Back-pressure: hold rsp_ready=0 for 5 cycles → rsp_valid and rsp_rdata stable, req_ready=0, a second req_valid is not accepted.
- Reset during WR: assert rst_n=0 while in WR → mem_writeEnable=0 immediately, rsp_valid=0, and after release the state is IDLE with req_ready=1.
